// File: rtl/truco_pkg.sv
// Shared truco definitions: round/winner codes, stake ladder, FSM states and the hand verdict rule.
package truco_pkg;

    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_P1   = 2'b01;
    localparam logic [1:0] R_P2   = 2'b10;
    localparam logic [1:0] R_TIE  = 2'b11;

    localparam logic [1:0] W_VOID = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;

    localparam logic [3:0] STAKE_1  = 4'd1;
    localparam logic [3:0] STAKE_3  = 4'd3;
    localparam logic [3:0] STAKE_6  = 4'd6;
    localparam logic [3:0] STAKE_9  = 4'd9;
    localparam logic [3:0] STAKE_12 = 4'd12;

    typedef enum logic [2:0] {
        ST_PLAY  = 3'd0,
        ST_JUDGE = 3'd1,
        ST_AWARD = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef struct packed {
        logic       decided;
        logic [1:0] winner;
    } verdict_t;

    function automatic logic [3:0] next_stake(input logic [3:0] s);
        case (s)
            STAKE_1: return STAKE_3;
            STAKE_3: return STAKE_6;
            STAKE_6: return STAKE_9;
            default: return STAKE_12;
        endcase
    endfunction

    // A slot that was played but still reads 00 counts as a tie.
    function automatic logic [1:0] as_result(input logic [1:0] c);
        return (c == R_NONE) ? R_TIE : c;
    endfunction

    // Round codes 01/10 coincide with winner codes 01/10, so results pass straight through.
    function automatic verdict_t judge_hand(input logic [1:0] count, input logic [1:0] s1,
                                            input logic [1:0] s2, input logic [1:0] s3);
        logic [1:0] r1, r2, r3;
        verdict_t   v;
        v.decided = 1'b0;
        v.winner  = W_VOID;
        r1 = R_TIE;
        r2 = R_TIE;
        r3 = R_TIE;
        case (count)
            2'd2: begin
                r1 = as_result(s2);
                r2 = as_result(s1);
                if (r1 != R_TIE && (r2 == r1 || r2 == R_TIE)) begin
                    v.decided = 1'b1;
                    v.winner  = r1;
                end else if (r1 == R_TIE && r2 != R_TIE) begin
                    v.decided = 1'b1;
                    v.winner  = r2;
                end
            end
            2'd3: begin
                r1 = as_result(s3);
                r2 = as_result(s2);
                r3 = as_result(s1);
                v.decided = 1'b1;
                if (r1 == R_TIE && r2 == R_TIE)
                    v.winner = (r3 == R_TIE) ? W_VOID : r3;
                else if (r1 != R_TIE && r2 != R_TIE && r1 != r2)
                    v.winner = (r3 == R_TIE) ? r1 : r3;
                else
                    v.winner = (r1 != R_TIE) ? r1 : r2;
            end
            default: ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/truco_hand_judge_stake_ladder.sv
// Current hand stake and the stake it had before the last accepted raise (the fold award).
module stake_ladder
    import truco_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       raise,
    input  logic       clear,
    output logic [3:0] stake,
    output logic [3:0] prev_stake
);

    logic [3:0] stake_q, prev_q;

    // A raise at 12 is a no-op, so the fold award stays at the last real step (9).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stake_q <= STAKE_1;
            prev_q  <= STAKE_1;
        end else if (clear) begin
            stake_q <= STAKE_1;
            prev_q  <= STAKE_1;
        end else if (raise && stake_q != STAKE_12) begin
            prev_q  <= stake_q;
            stake_q <= next_stake(stake_q);
        end
    end

    assign stake      = stake_q;
    assign prev_stake = prev_q;

endmodule

// File: rtl/truco_hand_judge.sv
// Truco hand judge: samples round results, decides and awards hands, tracks scores and game over.
module truco_hand_judge
    import truco_pkg::*;
#(
    parameter int WIN_SCORE = 12,
    parameter int SCORE_W   = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               round_done,
    input  logic [1:0]         S1,
    input  logic [1:0]         S2,
    input  logic [1:0]         S3,
    input  logic               raise,
    input  logic               fold_p1,
    input  logic               fold_p2,
    output logic [3:0]         stake,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         hand_winner,
    output logic               hand_done,
    output logic               rounds_clr,
    output logic               game_over,
    output logic [2:0]         dbg_state
);

    state_t             state_q;
    logic [1:0]         count_q, s1_q, s2_q, s3_q, hand_winner_q;
    logic [SCORE_W-1:0] score_p1_q, score_p2_q;
    logic               hand_done_q, rounds_clr_q, game_over_q;
    logic [3:0]         stake_cur, prev_stake;
    logic               raise_ok, fold_ok, ladder_clear;
    verdict_t           verdict;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [3:0] amt);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {{(SCORE_W-3){1'b0}}, amt};
        if (sum >= (SCORE_W+1)'(WIN_SCORE))
            return (SCORE_W)'(WIN_SCORE);
        return sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        raise_ok     = (state_q == ST_PLAY) && raise;
        fold_ok      = (state_q == ST_PLAY) && (fold_p1 ^ fold_p2);
        ladder_clear = (state_q == ST_CLEAR);
        verdict      = judge_hand(count_q, s1_q, s2_q, s3_q);
    end

    stake_ladder u_ladder (
        .clk       (clk),
        .clr       (clr),
        .raise     (raise_ok),
        .clear     (ladder_clear),
        .stake     (stake_cur),
        .prev_stake(prev_stake)
    );

    // Scores change on the same edge that raises hand_done, so they read final during AWARD.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= ST_PLAY;
            count_q       <= 2'd0;
            s1_q          <= R_NONE;
            s2_q          <= R_NONE;
            s3_q          <= R_NONE;
            score_p1_q    <= '0;
            score_p2_q    <= '0;
            hand_winner_q <= W_VOID;
            hand_done_q   <= 1'b0;
            rounds_clr_q  <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            hand_done_q   <= 1'b0;
            rounds_clr_q  <= 1'b0;
            hand_winner_q <= W_VOID;
            case (state_q)
                ST_PLAY: begin
                    if (fold_ok) begin
                        state_q     <= ST_AWARD;
                        hand_done_q <= 1'b1;
                        if (fold_p1) begin
                            hand_winner_q <= W_P2;
                            score_p2_q    <= sat_add(score_p2_q, prev_stake);
                        end else begin
                            hand_winner_q <= W_P1;
                            score_p1_q    <= sat_add(score_p1_q, prev_stake);
                        end
                    end else if (round_done) begin
                        s1_q    <= S1;
                        s2_q    <= S2;
                        s3_q    <= S3;
                        count_q <= (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
                        state_q <= ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    if (verdict.decided) begin
                        state_q       <= ST_AWARD;
                        hand_done_q   <= 1'b1;
                        hand_winner_q <= verdict.winner;
                        if (verdict.winner == W_P1)
                            score_p1_q <= sat_add(score_p1_q, stake_cur);
                        else if (verdict.winner == W_P2)
                            score_p2_q <= sat_add(score_p2_q, stake_cur);
                    end else begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_AWARD: begin
                    state_q      <= ST_CLEAR;
                    rounds_clr_q <= 1'b1;
                end
                ST_CLEAR: begin
                    count_q <= 2'd0;
                    s1_q    <= R_NONE;
                    s2_q    <= R_NONE;
                    s3_q    <= R_NONE;
                    if (score_p1_q == (SCORE_W)'(WIN_SCORE) ||
                        score_p2_q == (SCORE_W)'(WIN_SCORE)) begin
                        state_q     <= ST_OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q <= ST_PLAY;
                    end
                end
                default: begin
                    state_q     <= ST_OVER;
                    game_over_q <= 1'b1;
                end
            endcase
        end
    end

    assign stake       = stake_cur;
    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign hand_winner = hand_winner_q;
    assign hand_done   = hand_done_q;
    assign rounds_clr  = rounds_clr_q;
    assign game_over   = game_over_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_truco_hand_judge.sv
// Directed bench for truco_hand_judge: hand-computed scores, latencies, folds, raises, clr and game over.
module tb_truco_hand_judge;
    import truco_pkg::*;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       round_done = 1'b0;
    logic [1:0] S1 = 2'b00, S2 = 2'b00, S3 = 2'b00;
    logic       raise = 1'b0, fold_p1 = 1'b0, fold_p2 = 1'b0;
    logic [3:0] stake;
    logic [4:0] score_p1, score_p2;
    logic [1:0] hand_winner;
    logic       hand_done, rounds_clr, game_over;
    logic [2:0] dbg_state;

    int tests = 0;
    int fails = 0;

    truco_hand_judge #(.WIN_SCORE(12), .SCORE_W(5)) dut (
        .clk        (clk),
        .clr        (clr),
        .round_done (round_done),
        .S1         (S1),
        .S2         (S2),
        .S3         (S3),
        .raise      (raise),
        .fold_p1    (fold_p1),
        .fold_p2    (fold_p2),
        .stake      (stake),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .hand_winner(hand_winner),
        .hand_done  (hand_done),
        .rounds_clr (rounds_clr),
        .game_over  (game_over),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present decoder contents and pulse round_done; returns one cycle later (state JUDGE).
    task automatic round(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        S1 = a; S2 = b; S3 = c;
        round_done = 1'b1;
        tick();
        round_done = 1'b0;
    endtask

    task automatic do_raise(input int n);
        for (int i = 0; i < n; i++) begin
            raise = 1'b1;
            tick();
            raise = 1'b0;
        end
    endtask

    task automatic hand_p1();
        round(2'b01, 2'b00, 2'b00);
        tick();
        round(2'b01, 2'b01, 2'b00);
        tick();
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        clr = 1'b0;
        tick();
        check("rst_stake", stake, 1);
        check("rst_p1", score_p1, 0);
        check("rst_p2", score_p2, 0);
        check("rst_winner", hand_winner, 0);
        check("rst_done", hand_done, 0);
        check("rst_rclr", rounds_clr, 0);
        check("rst_over", game_over, 0);
        check("rst_state", dbg_state, ST_PLAY);

        // P1,P1: hand_done two cycles after round 2, rounds_clr one more later
        round(2'b01, 2'b00, 2'b00);
        check("pp_r1_nodone", hand_done, 0);
        tick();
        round(2'b01, 2'b01, 2'b00);
        check("pp_judge_nodone", hand_done, 0);
        tick();
        check("pp_done", hand_done, 1);
        check("pp_winner", hand_winner, 2'b01);
        check("pp_p1", score_p1, 1);
        check("pp_rclr_early", rounds_clr, 0);
        tick();
        check("pp_rclr", rounds_clr, 1);
        check("pp_done_pulse", hand_done, 0);
        tick();
        check("pp_rclr_pulse", rounds_clr, 0);

        // tie,P2
        round(2'b11, 2'b00, 2'b00);
        tick();
        round(2'b10, 2'b11, 2'b00);
        tick();
        check("tp_done", hand_done, 1);
        check("tp_winner", hand_winner, 2'b10);
        check("tp_p2", score_p2, 1);
        tick();
        tick();

        // P1,P2,tie: first round decides
        round(2'b01, 2'b00, 2'b00);
        tick();
        round(2'b10, 2'b01, 2'b00);
        tick();
        check("ppt_split_nodone", hand_done, 0);
        round(2'b11, 2'b10, 2'b01);
        tick();
        check("ppt_done", hand_done, 1);
        check("ppt_winner", hand_winner, 2'b01);
        check("ppt_p1", score_p1, 2);
        tick();
        tick();

        // tie,tie,tie: void
        round(2'b11, 2'b00, 2'b00);
        tick();
        round(2'b11, 2'b11, 2'b00);
        tick();
        round(2'b11, 2'b11, 2'b11);
        tick();
        check("ttt_done", hand_done, 1);
        check("ttt_winner", hand_winner, 2'b00);
        check("ttt_p1", score_p1, 2);
        check("ttt_p2", score_p2, 1);
        tick();
        tick();

        // raise x2 then P2,P2 worth 6
        do_raise(2);
        check("r2_stake", stake, 6);
        round(2'b10, 2'b00, 2'b00);
        tick();
        round(2'b10, 2'b10, 2'b00);
        tick();
        check("r2_winner", hand_winner, 2'b10);
        check("r2_p2", score_p2, 7);
        tick();
        tick();
        check("r2_stake_cleared", stake, 1);

        // raise then fold_p1: award is the pre-raise stake, one cycle latency
        do_raise(1);
        check("rf_stake", stake, 3);
        fold_p1 = 1'b1;
        tick();
        fold_p1 = 1'b0;
        check("rf_done", hand_done, 1);
        check("rf_winner", hand_winner, 2'b10);
        check("rf_p2", score_p2, 8);
        tick();
        tick();

        // both folds at once are ignored
        fold_p1 = 1'b1;
        fold_p2 = 1'b1;
        tick();
        fold_p1 = 1'b0;
        fold_p2 = 1'b0;
        check("ff_nodone", hand_done, 0);
        check("ff_state", dbg_state, ST_PLAY);

        // fold_p2 with round_done: the fold wins, P1 gets 1
        fold_p2 = 1'b1;
        round(2'b10, 2'b00, 2'b00);
        fold_p2 = 1'b0;
        check("fr_done", hand_done, 1);
        check("fr_winner", hand_winner, 2'b01);
        check("fr_p1", score_p1, 3);
        check("fr_p2", score_p2, 8);
        tick();
        tick();

        // clr during AWARD clears everything asynchronously
        do_raise(1);
        round(2'b01, 2'b00, 2'b00);
        tick();
        round(2'b01, 2'b01, 2'b00);
        tick();
        check("ca_done", hand_done, 1);
        check("ca_p1", score_p1, 6);
        #2;
        clr = 1'b1;
        #1;
        check("ca_stake", stake, 1);
        check("ca_p1_zero", score_p1, 0);
        check("ca_p2_zero", score_p2, 0);
        check("ca_done_zero", hand_done, 0);
        check("ca_winner_zero", hand_winner, 0);
        tick();
        clr = 1'b0;
        tick();
        check("ca_state", dbg_state, ST_PLAY);
        round(2'b10, 2'b00, 2'b00);
        tick();
        round(2'b10, 2'b10, 2'b00);
        tick();
        check("ca_next_p2", score_p2, 1);
        check("ca_next_p1", score_p1, 0);
        tick();
        tick();

        // raise x5 saturates at 12; a void hand then leaves scores alone
        do_raise(5);
        check("r5_stake", stake, 12);
        round(2'b11, 2'b00, 2'b00);
        tick();
        round(2'b11, 2'b11, 2'b00);
        tick();
        round(2'b11, 2'b11, 2'b11);
        tick();
        check("r5_void", hand_winner, 2'b00);
        check("r5_p2", score_p2, 1);
        tick();
        tick();

        // climb P1 to 11: 9 + 1 + 1
        do_raise(3);
        hand_p1();
        check("climb_9", score_p1, 9);
        hand_p1();
        hand_p1();
        check("climb_11", score_p1, 11);
        check("climb_not_over", game_over, 0);

        // 11 + 3 saturates at 12 and ends the game
        do_raise(1);
        round(2'b01, 2'b00, 2'b00);
        tick();
        round(2'b01, 2'b01, 2'b00);
        tick();
        check("go_p1", score_p1, 12);
        tick();
        check("go_rclr", rounds_clr, 1);
        tick();
        check("go_over", game_over, 1);
        check("go_state", dbg_state, ST_OVER);

        // OVER ignores everything
        do_raise(1);
        round(2'b10, 2'b10, 2'b10);
        fold_p1 = 1'b1;
        tick();
        fold_p1 = 1'b0;
        tick();
        tick();
        check("ov_stake", stake, 1);
        check("ov_p1", score_p1, 12);
        check("ov_p2", score_p2, 1);
        check("ov_done", hand_done, 0);
        check("ov_over", game_over, 1);

        clr = 1'b1;
        #1;
        check("ov_clr_over", game_over, 0);
        check("ov_clr_p1", score_p1, 0);
        tick();
        clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
